// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-index counter width: max(1, $clog2(width)).
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// Purely combinational 1-bit full adder cell.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: latches operands, then adds one bit per clock, LSB first,
// through a single full-adder cell, with valid/ready handshakes on both sides.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             busy
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'((WIDTH >= 2) ? WIDTH - 2 : 0);
  localparam bit               SINGLE   = (WIDTH == 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             load_ops;
  logic             fa_s, fa_co;
  logic             msb_cin;

  fa_bit u_fa (
    .a  (opa_q[cnt_q]),
    .b  (opb_q[cnt_q]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // With one bit there is no earlier cycle to capture cmsb; the latched ci is the MSB carry-in.
  assign msb_cin = SINGLE ? carry_q : cmsb_q;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cmsb_d   = cmsb_q;
    sum_d    = sum_q;
    co_d     = co_q;
    ovf_d    = ovf_q;
    load_ops = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_ops = 1'b1;
          carry_d  = ci;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sum_d[cnt_q] = fa_s;
        carry_d      = fa_co;
        if (cnt_q == CNT_PEN) cmsb_d = fa_co;
        if (cnt_q == CNT_LAST) begin
          co_d    = fa_co;
          ovf_d   = msb_cin ^ fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: operand and cmsb registers are always written before being read, so they carry no reset.
  always_ff @(posedge clk) begin
    cmsb_q <= cmsb_d;
    if (load_ops) begin
      opa_q <= a;
      opb_q <= b;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign sum       = sum_q;
  assign co        = co_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: WIDTH=8 instance with randomized operands and a WIDTH=1 instance.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         ci = 1'b0;
  logic         in_ready, out_valid, co, ovf, busy;
  logic [W-1:0] sum;

  logic         in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [0:0]   a1 = '0, b1 = '0, sum1;
  logic         ci1 = 1'b0;
  logic         in_ready1, out_valid1, co1, ovf1, busy1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co), .ovf(ovf), .busy(busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .ci(ci1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .co(co1), .ovf(ovf1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({co, ovf, sum} !== '0) begin failures++; $display("FAIL reset_result got co=%b ovf=%b sum=%h exp all 0", co, ovf, sum); end
    checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || busy1 !== 1'b0) begin
      failures++; $display("FAIL reset_w1 got in_ready=%b out_valid=%b busy=%b exp 1/0/0", in_ready1, out_valid1, busy1);
    end
  endtask

  // One full transaction from IDLE; result checked against plain arithmetic.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci,
                       input int hold, input bit scramble, input bit valid_in_done, input string tag);
    logic [W:0]   full;
    logic [W-1:0] es;
    logic         eco, eovf;
    int           nbusy, cyc;
    full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tci};
    es   = full[W-1:0];
    eco  = full[W];
    eovf = (ta[W-1] == tb[W-1]) && (es[W-1] != ta[W-1]);

    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL %s_ready_before got=%b exp=1", tag, in_ready); end
    a = ta; b = tb; ci = tci; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (scramble) begin a = 8'h33; b = 8'h33; ci = ~tci; end

    nbusy = 0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 4 * W) begin
      if (busy === 1'b1 && in_ready === 1'b0) nbusy++;
      tick();
      cyc++;
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL %s_timeout out_valid=%b after %0d cycles exp=1", tag, out_valid, cyc); end
    checks++; if (nbusy !== W) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", tag, nbusy, W); end
    checks++; if (sum !== es || co !== eco || ovf !== eovf) begin
      failures++; $display("FAIL %s_result got sum=%h co=%b ovf=%b exp sum=%h co=%b ovf=%b", tag, sum, co, ovf, es, eco, eovf);
    end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL %s_done_flags got busy=%b in_ready=%b exp 0/0", tag, busy, in_ready);
    end

    if (valid_in_done) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== es || co !== eco || ovf !== eovf) begin
        failures++;
        $display("FAIL %s_hold%0d got v=%b r=%b sum=%h co=%b ovf=%b exp v=1 r=0 sum=%h co=%b ovf=%b",
                 tag, i, out_valid, in_ready, sum, co, ovf, es, eco, eovf);
      end
    end

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL %s_release got in_ready=%b out_valid=%b exp 1/0", tag, in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    do_op(8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b0, "zero");
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0, "ff_01");
    do_op(8'h7F, 8'h01, 1'b0, 1, 1'b0, 1'b0, "7f_01");
    do_op(8'h80, 8'h80, 1'b1, 0, 1'b0, 1'b0, "80_80");
  endtask

  task automatic test_operand_isolation();
    do_op(8'hA5, 8'h5A, 1'b1, 2, 1'b1, 1'b0, "a5_5a_scramble");
  endtask

  task automatic test_back_to_back();
    do_op(W'($urandom), W'($urandom), 1'($urandom), 5, 1'b0, 1'b1, "stall5");
    do_op(W'($urandom), W'($urandom), 1'($urandom), 0, 1'b0, 1'b0, "b2b");
  endtask

  task automatic test_reset_abort();
    a = 8'hC3; b = 8'h3C; ci = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || co !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL abort_state got r=%b v=%b busy=%b sum=%h co=%b ovf=%b exp 1/0/0/00/0/0", in_ready, out_valid, busy, sum, co, ovf);
    end
    // Reset must win over an accept handshake on the same edge.
    a = 8'h11; b = 8'h22; in_valid = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_beats_accept got busy=%b in_ready=%b exp 0/1", busy, in_ready);
    end
    do_op(8'h10, 8'h20, 1'b0, 0, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), "rand");
    end
  endtask

  task automatic test_width1();
    logic [1:0] full;
    logic       eovf;
    int         cyc;
    for (int k = 0; k < 8; k++) begin
      a1 = 1'(k >> 2); b1 = 1'(k >> 1); ci1 = 1'(k);
      full = {1'b0, a1} + {1'b0, b1} + {1'b0, ci1};
      eovf = (a1 == b1) && (full[0] != a1[0]);
      in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      a1 = ~a1; b1 = ~b1; ci1 = ~ci1;
      checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL w1_busy_%0d got=%b exp=1", k, busy1); end
      cyc = 0;
      while (out_valid1 !== 1'b1 && cyc < 4) begin tick(); cyc++; end
      checks++; if (cyc !== 1) begin failures++; $display("FAIL w1_latency_%0d got=%0d exp=1", k, cyc); end
      checks++; if ({co1, sum1} !== full || ovf1 !== eovf) begin
        failures++; $display("FAIL w1_result_%0d got co=%b sum=%b ovf=%b exp co=%b sum=%b ovf=%b", k, co1, sum1, ovf1, full[1], full[0], eovf);
      end
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL w1_release_%0d got=%b exp=1", k, in_ready1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_operand_isolation();
    test_back_to_back();
    test_reset_abort();
    test_random();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
